// File: rtl/decoder_host_driver_pkg.sv
// decoder_host_driver_pkg: shared link constants, driver state enum and derived-width helpers
package decoder_host_driver_pkg;

  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h01;
  localparam logic [7:0] START_DECODING_MSG = 8'h02;

  typedef enum logic [3:0] {
    IDLE,
    SEND_HEADER,
    LOAD_ROUND,
    SEND_ROUND,
    RECV_ITER,
    RECV_CYC_HI,
    RECV_CYC_LO,
    RECV_CORR,
    EMIT_CORR
  } state_t;

  function automatic int bytes_per_round(input int x, input int z);
    return (x * z + 7) / 8;
  endfunction

  function automatic int corr_count(input int x, input int z);
    return (x + 1) * (z + 1);
  endfunction

  function automatic int corr_bytes(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/decoder_host_driver_byte_deserializer.sv
// byte_deserializer: packs LSB-first bytes into one WIDTH-bit word, extra high bits dropped
module byte_deserializer
  import decoder_host_driver_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NB = corr_bytes(WIDTH);
  localparam int AW = NB * 8;
  localparam int CW = $clog2(NB + 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  assign in_ready = !out_valid;
  assign in_last = cnt == CW'(NB - 1);
  assign out_data = acc[WIDTH-1:0];

  // each byte enters at the top so the first byte ends up in the low bits
  always_ff @(posedge clk)
    if (!reset || clr) begin
      acc <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc <= AW'({in_data, acc} >> 8);
        cnt <= in_last ? '0 : cnt + 1'b1;
      end
      out_valid <= (in_valid && in_ready && in_last) || (out_valid && !out_ready);
    end

endmodule

// File: rtl/decoder_host_driver.sv
// decoder_host_driver: serializes measurement rounds to the decoder link and parses its results; HOST_RX_TIMEOUT_EN adds an rx watchdog
module decoder_host_driver
  import decoder_host_driver_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3,
  parameter int NUM_CONTEXTS = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ALIGNED_PU_PER_ROUND = 8 * bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z),
  localparam int CORRECTION_COUNT_PER_ROUND = corr_count(GRID_WIDTH_X, GRID_WIDTH_Z)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ALIGNED_PU_PER_ROUND-1:0]       meas_data,
  input  logic                                  meas_valid,
  output logic                                  meas_ready,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  input  logic [7:0]                            rx_data,
  input  logic                                  rx_valid,
  output logic                                  rx_ready,
  output logic [CORRECTION_COUNT_PER_ROUND-1:0] corr_data,
  output logic                                  corr_valid,
  input  logic                                  corr_ready,
  output logic [7:0]                            iteration_count,
  output logic [15:0]                           cycle_count,
  output logic                                  stats_valid,
  output logic                                  busy,
  output logic                                  timeout_err
);

  localparam int BYTES_PER_ROUND = bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z);
  localparam int CORR_BYTES = corr_bytes(CORRECTION_COUNT_PER_ROUND);
  localparam int PHYS_U = GRID_WIDTH_U / NUM_CONTEXTS + 1;
  localparam int TOTAL_ROUNDS = PHYS_U * NUM_CONTEXTS;
  localparam int RW = $clog2(TOTAL_ROUNDS + 1);
  localparam int BW = $clog2((BYTES_PER_ROUND > CORR_BYTES ? BYTES_PER_ROUND : CORR_BYTES) + 1);

  state_t state, next_state;
  logic [ALIGNED_PU_PER_ROUND-1:0] shift_q;
  logic [BW-1:0] byte_cnt;
  logic [RW-1:0] round_cnt, word_cnt;
  logic rx_hs, corr_in_valid, corr_in_ready, corr_last, timeout_hit;

  assign tx_valid = state == SEND_HEADER || state == SEND_ROUND;
  assign tx_data = state == SEND_HEADER ? MEASUREMENT_DATA_HEADER : shift_q[7:0];
  assign meas_ready = state == LOAD_ROUND;
  assign busy = state != IDLE;
  assign rx_hs = rx_valid && rx_ready;
  assign corr_in_valid = rx_hs && corr_in_ready && state == RECV_CORR;

  byte_deserializer #(.WIDTH(CORRECTION_COUNT_PER_ROUND)) u_corr (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE),
    .in_data(rx_data),
    .in_valid(corr_in_valid),
    .in_ready(corr_in_ready),
    .in_last(corr_last),
    .out_data(corr_data),
    .out_valid(corr_valid),
    .out_ready(corr_ready)
  );

  // frame sequencing: header, rounds back to back, then stats and correction words
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (meas_valid) next_state = SEND_HEADER;
      SEND_HEADER: if (tx_ready) next_state = LOAD_ROUND;
      LOAD_ROUND:  if (meas_valid) next_state = SEND_ROUND;
      SEND_ROUND:
        if (tx_ready && byte_cnt == BW'(BYTES_PER_ROUND - 1))
          next_state = round_cnt == RW'(TOTAL_ROUNDS - 1) ? RECV_ITER : LOAD_ROUND;
      RECV_ITER:   if (rx_hs) next_state = RECV_CYC_HI;
      RECV_CYC_HI: if (rx_hs) next_state = RECV_CYC_LO;
      RECV_CYC_LO: if (rx_hs) next_state = RECV_CORR;
      RECV_CORR:   if (corr_in_valid && corr_last) next_state = EMIT_CORR;
      EMIT_CORR:
        if (corr_valid && corr_ready)
          next_state = word_cnt == RW'(TOTAL_ROUNDS - 1) ? IDLE : RECV_CORR;
      default:     next_state = IDLE;
    endcase
    if (timeout_hit) next_state = IDLE;
  end

  // state, round shifter, counters, registered rx_ready and latched stats
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      shift_q <= '0;
      byte_cnt <= '0;
      round_cnt <= '0;
      word_cnt <= '0;
      rx_ready <= 1'b0;
      iteration_count <= '0;
      cycle_count <= '0;
      stats_valid <= 1'b0;
    end else begin
      state <= next_state;
      rx_ready <= next_state inside {RECV_ITER, RECV_CYC_HI, RECV_CYC_LO, RECV_CORR};
      stats_valid <= state == RECV_CYC_LO && rx_hs;
      if (state == IDLE) begin
        round_cnt <= '0;
        word_cnt <= '0;
      end
      if (meas_ready && meas_valid) begin
        shift_q <= meas_data;
        byte_cnt <= '0;
      end else if (state == SEND_ROUND && tx_ready) begin
        shift_q <= shift_q >> 8;
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == BW'(BYTES_PER_ROUND - 1)) round_cnt <= round_cnt + 1'b1;
      end
      if (rx_hs && state == RECV_ITER) iteration_count <= rx_data;
      if (rx_hs && state == RECV_CYC_HI) cycle_count[15:8] <= rx_data;
      if (rx_hs && state == RECV_CYC_LO) cycle_count[7:0] <= rx_data;
      if (state == EMIT_CORR && corr_valid && corr_ready) word_cnt <= word_cnt + 1'b1;
    end

`ifdef HOST_RX_TIMEOUT_EN
  logic [31:0] wdog;
  logic recv;

  assign recv = state inside {RECV_ITER, RECV_CYC_HI, RECV_CYC_LO, RECV_CORR};
  assign timeout_hit = recv && !rx_hs && wdog == 32'(TIMEOUT_CYCLES - 1);

  // idle-link watchdog; any accepted rx byte restarts it, the error flag is sticky
  always_ff @(posedge clk)
    if (!reset) begin
      wdog <= '0;
      timeout_err <= 1'b0;
    end else begin
      wdog <= recv && !rx_hs && !timeout_hit ? wdog + 32'd1 : '0;
      timeout_err <= timeout_err || timeout_hit;
    end
`else
  logic unused_timeout;

  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_decoder_host_driver.sv
// tb_decoder_host_driver: randomized frames against a byte-level model of the host link
module tb_decoder_host_driver;
  import decoder_host_driver_pkg::*;

  localparam int TOTAL = 4;
  localparam int BPR = 1;
  localparam int CB = 2;
  localparam int NRESP = 3 + TOTAL * CB;
`ifdef HOST_RX_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] meas_data;
  logic meas_valid, meas_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready;
  logic [9:0] corr_data;
  logic corr_valid;
  logic corr_ready = 1'b1;
  logic [7:0] iteration_count;
  logic [15:0] cycle_count;
  logic stats_valid, busy, timeout_err;

  decoder_host_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .meas_data(meas_data),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .corr_data(corr_data),
    .corr_valid(corr_valid),
    .corr_ready(corr_ready),
    .iteration_count(iteration_count),
    .cycle_count(cycle_count),
    .stats_valid(stats_valid),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] m_q[$], r_q[$], tx_log[$];
  logic [9:0] corr_log[$];
  int m_idx = 0, r_idx = 0, m_skip = 0, r_skip = 0;
  int meas_rdy_cycles = 0, stats_pulses = 0;
  int checks = 0, errors = 0;
  bit tx_toggle = 0, tx_block = 0, rx_gaps = 0, tx_stalled = 0;
  logic [7:0] tx_hold = 8'h00;
  int stall_word = -1, stall_left = 0, stall_exp = 0;
  logic [7:0] f_round[TOTAL];
  logic [7:0] f_resp[NRESP];
  int tx_base, corr_base, r_base, mr_base, sp_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // record what the DUT actually accepted / emitted on each edge
  always @(posedge clk)
    if (reset) begin
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (corr_valid && corr_ready) corr_log.push_back(corr_data);
      if (meas_valid && meas_ready) m_idx <= m_idx + 1;
      if (rx_valid && rx_ready) r_idx <= r_idx + 1;
      if (meas_ready) meas_rdy_cycles <= meas_rdy_cycles + 1;
      if (stats_valid) stats_pulses <= stats_pulses + 1;
    end

  // drive sources/sinks away from the active edge and check stall behaviour
  always @(negedge clk) begin
    if (tx_stalled && reset) begin
      chk("tx_valid_hold", tx_valid, 1);
      chk("tx_data_hold", tx_data, tx_hold);
    end
    tx_ready = tx_block ? 1'b0 : tx_toggle ? !tx_ready : 1'b1;
    tx_stalled = reset && tx_valid && !tx_ready;
    tx_hold = tx_data;
    meas_valid = m_idx + m_skip < m_q.size();
    meas_data = meas_valid ? m_q[m_idx + m_skip] : 8'h00;
    rx_valid = r_idx + r_skip < r_q.size() && (!rx_gaps || $urandom_range(0, 3) != 0);
    rx_data = r_idx + r_skip < r_q.size() ? r_q[r_idx + r_skip] : 8'h00;
    if (stall_left > 0 && corr_valid && corr_log.size() == stall_word) begin
      corr_ready = 1'b0;
      chk("stall_rx_ready", rx_ready, 0);
      chk("stall_corr_data", corr_data, stall_exp);
      stall_left--;
    end else corr_ready = 1'b1;
  end

  task automatic rand_frame();
    foreach (f_round[i]) f_round[i] = 8'($urandom_range(0, 15));
    foreach (f_resp[i]) f_resp[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic load_frame(input int nresp);
    tx_base = tx_log.size();
    corr_base = corr_log.size();
    r_base = r_idx;
    mr_base = meas_rdy_cycles;
    sp_base = stats_pulses;
    foreach (f_round[i]) m_q.push_back(f_round[i]);
    for (int i = 0; i < nresp; i++) r_q.push_back(f_resp[i]);
  endtask

  task automatic finish_frame(input int fn);
    int n = 0;
    int w;
    while (!(corr_log.size() >= corr_base + TOTAL && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("f%0d_done", fn), n < 3000, 1);
    chk($sformatf("f%0d_tx_count", fn), tx_log.size() - tx_base, 1 + TOTAL * BPR);
    chk($sformatf("f%0d_tx_header", fn),
        tx_base < tx_log.size() ? tx_log[tx_base] : 8'hxx, MEASUREMENT_DATA_HEADER);
    for (int i = 0; i < TOTAL; i++)
      chk($sformatf("f%0d_tx_round%0d", fn, i),
          tx_base + 1 + i < tx_log.size() ? tx_log[tx_base + 1 + i] : 8'hxx, f_round[i]);
    chk($sformatf("f%0d_iteration", fn), iteration_count, f_resp[0]);
    chk($sformatf("f%0d_cycles", fn), cycle_count, f_resp[1] * 256 + f_resp[2]);
    chk($sformatf("f%0d_stats_pulses", fn), stats_pulses - sp_base, 1);
    chk($sformatf("f%0d_meas_ready_cycles", fn), meas_rdy_cycles - mr_base, TOTAL);
    chk($sformatf("f%0d_rx_consumed", fn), r_idx - r_base, NRESP);
    for (int k = 0; k < TOTAL; k++) begin
      w = (f_resp[3 + 2 * k] + 256 * f_resp[4 + 2 * k]) % 1024;
      chk($sformatf("f%0d_corr%0d", fn, k),
          corr_base + k < corr_log.size() ? corr_log[corr_base + k] : 10'hxxx, w);
    end
    chk($sformatf("f%0d_idle", fn), busy, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_meas_ready", meas_ready, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_corr_valid", corr_valid, 0);
    chk("rst_stats_valid", stats_valid, 0);
    chk("rst_iteration", iteration_count, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b1;
    @(negedge clk);

    f_round = '{8'h05, 8'h0A, 8'h0F, 8'h01};
    f_resp = '{8'h07, 8'h00, 8'h2A, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h0B, 8'h00};
    load_frame(NRESP);
    finish_frame(1);

    rand_frame();
    tx_toggle = 1;
    rx_gaps = 1;
    stall_word = corr_log.size() + 2;
    stall_left = 10;
    stall_exp = (f_resp[7] + 256 * f_resp[8]) % 1024;
    load_frame(NRESP);
    finish_frame(2);
    chk("f2_stall_done", stall_left, 0);
    tx_toggle = 0;
    rx_gaps = 0;

    rand_frame();
    load_frame(NRESP);
    n = 0;
    while (tx_log.size() < tx_base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_progress", n < 200, 1);
    tx_block = 1;
    repeat (2) @(negedge clk);
    chk("mid_in_send_round", tx_valid, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_meas_ready", meas_ready, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_corr_valid", corr_valid, 0);
    chk("mid_rst_no_corr", corr_log.size() - corr_base, 0);
    m_skip = m_q.size() - m_idx;
    r_skip = r_q.size() - r_idx;
    tx_block = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rand_frame();
    load_frame(NRESP);
    finish_frame(3);

`ifdef HOST_RX_TIMEOUT_EN
    rand_frame();
    load_frame(0);
    n = 0;
    while (tx_log.size() < tx_base + 1 + TOTAL && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_tx_sent", n < 200, 1);
    n = 0;
    while (!timeout_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TMO);
    chk("to_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    chk("to_rx_ready", rx_ready, 0);
`else
    chk("timeout_tied_low", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed hang expected finish");
    $fatal(1);
  end

endmodule
